// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light sequencer.
// Contents: state encoding (3-bit enum), one-hot lamp codes {red, yellow, green},
//           and a helper that identifies the pedestrian walk states.
package traffic_pkg;

    typedef enum logic [2:0] {
        ALLRED_B  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_A  = 3'd3,
        WALK_A    = 3'd4,
        EW_GREEN  = 3'd5,
        EW_YELLOW = 3'd6,
        WALK_B    = 3'd7
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    function automatic logic is_walk(input state_t s);
        return (s == WALK_A) || (s == WALK_B);
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Phase dwell down-counter: load sets the count, each tick decrements it while nonzero.
// Ports: clk/reset (async, active-high), load + load_val (load has priority), tick,
//        done = tick && count==0, combinational from the registered count (0-cycle latency).
module dwell_timer #(
    parameter int              CNT_W   = 4,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= RST_VAL;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign done = tick && (r_cnt == '0);

endmodule

// File: rtl/traffic_light_sequencer.sv
// Two-way intersection sequencer: green/yellow/all-red phases with pedestrian walk insertion.
// Ports: clk, reset (async, active-high), tick (prescaler enable), ped_req (button);
//        registered outputs ns_light/ew_light {r,y,g}, walk, ped_ack, state; 1 clk after deciding tick.
module traffic_light_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int WALK_TICKS   = 4,
    parameter int CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] state
);

    // Counters hold TICKS-1, so a TICKS value of 2^CNT_W still fits.
    localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_TICKS  - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_TICKS - 1);
    localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_TICKS   - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic             w_done;
    logic [CNT_W-1:0] w_load_val;
    logic             w_enter_walk;
    logic             w_ped_pending_nxt;
    logic [2:0]       w_ns_nxt;
    logic [2:0]       w_ew_nxt;
    logic             w_walk_nxt;

    logic             r_ped_pending;
    logic [2:0]       r_ns_light;
    logic [2:0]       r_ew_light;
    logic             r_walk;
    logic             r_ped_ack;

    // Every transition happens on done, so done doubles as the reload strobe for the next phase.
    dwell_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (ALLRED_LD)
    ) u_dwell (
        .clk      (clk),
        .reset    (reset),
        .load     (w_done),
        .load_val (w_load_val),
        .tick     (tick),
        .done     (w_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ALLRED_B;
            r_ped_pending <= 1'b0;
            r_ns_light    <= LAMP_RED;
            r_ew_light    <= LAMP_RED;
            r_walk        <= 1'b0;
            r_ped_ack     <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_ped_pending <= w_ped_pending_nxt;
            r_ns_light    <= w_ns_nxt;
            r_ew_light    <= w_ew_nxt;
            r_walk        <= w_walk_nxt;
            r_ped_ack     <= w_enter_walk;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_done) begin
            case (r_state)
                ALLRED_B:  w_next_state = r_ped_pending ? WALK_B : NS_GREEN;
                NS_GREEN:  w_next_state = NS_YELLOW;
                NS_YELLOW: w_next_state = ALLRED_A;
                ALLRED_A:  w_next_state = r_ped_pending ? WALK_A : EW_GREEN;
                WALK_A:    w_next_state = EW_GREEN;
                EW_GREEN:  w_next_state = EW_YELLOW;
                EW_YELLOW: w_next_state = ALLRED_B;
                WALK_B:    w_next_state = NS_GREEN;
                default:   w_next_state = ALLRED_B;
            endcase
        end

        w_load_val = ALLRED_LD;
        case (w_next_state)
            NS_GREEN, EW_GREEN:   w_load_val = GREEN_LD;
            NS_YELLOW, EW_YELLOW: w_load_val = YELLOW_LD;
            WALK_A, WALK_B:       w_load_val = WALK_LD;
            default:              w_load_val = ALLRED_LD;
        endcase

        // Clear on walk entry beats a coincident request; requests during walk are ignored.
        w_enter_walk      = w_done && is_walk(w_next_state);
        w_ped_pending_nxt = r_ped_pending;
        if (w_enter_walk) begin
            w_ped_pending_nxt = 1'b0;
        end else if (ped_req && !is_walk(r_state)) begin
            w_ped_pending_nxt = 1'b1;
        end

        // Lamps are decoded from the next state so they register alongside it.
        w_ns_nxt   = LAMP_RED;
        w_ew_nxt   = LAMP_RED;
        w_walk_nxt = is_walk(w_next_state);
        case (w_next_state)
            NS_GREEN:  w_ns_nxt = LAMP_GRN;
            NS_YELLOW: w_ns_nxt = LAMP_YEL;
            EW_GREEN:  w_ew_nxt = LAMP_GRN;
            EW_YELLOW: w_ew_nxt = LAMP_YEL;
            default: begin
                w_ns_nxt = LAMP_RED;
                w_ew_nxt = LAMP_RED;
            end
        endcase
    end

    assign state    = r_state;
    assign ns_light = r_ns_light;
    assign ew_light = r_ew_light;
    assign walk     = r_walk;
    assign ped_ack  = r_ped_ack;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed bench for traffic_light_sequencer with default parameters.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Each scenario task carries its own comparisons against hand-derived values.
module tb_traffic_light_sequencer;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       ped_req;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       walk;
    logic       ped_ack;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    traffic_light_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .ped_req  (ped_req),
        .ns_light (ns_light),
        .ew_light (ew_light),
        .walk     (walk),
        .ped_ack  (ped_ack),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] exp_ns(input logic [2:0] s);
        case (s)
            3'd1:    return 3'b001;
            3'd2:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] exp_ew(input logic [2:0] s);
        case (s)
            3'd5:    return 3'b001;
            3'd6:    return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        tick    = 1'b0;
        ped_req = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Bounded wait; a timeout is recorded as a failed comparison.
    task automatic wait_state(input logic [2:0] target, input int max_cyc, input string tag);
        int n = 0;
        while (state !== target && n < max_cyc) begin
            step();
            n++;
        end
        checks++;
        if (state !== target) begin
            errors++;
            $display("FAIL %s: timeout, state=%0d required=%0d", tag, state, target);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tick = 1'b1; ped_req = 1'b1;
        step();
        checks++;
        if (state !== 3'd0 || ns_light !== 3'b100 || ew_light !== 3'b100 ||
            walk !== 1'b0 || ped_ack !== 1'b0 || dut.r_ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: state=%0d ns=%b ew=%b walk=%b ack=%b pend=%b required 0/100/100/0/0/0",
                     state, ns_light, ew_light, walk, ped_ack, dut.r_ped_pending);
        end
        do_reset();
    endtask

    task automatic test_normal_cycle();
        logic [2:0] exp_seq[$];
        logic [2:0] ph_s[6] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd0};
        int         ph_d[6] = '{8, 2, 1, 8, 2, 1};
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < 6; p++)
                for (int d = 0; d < ph_d[p]; d++)
                    exp_seq.push_back(ph_s[p]);
        tick = 1'b1;
        for (int k = 0; k < 44; k++) begin
            step();
            checks++;
            if (state !== exp_seq[k] || ns_light !== exp_ns(exp_seq[k]) ||
                ew_light !== exp_ew(exp_seq[k]) || walk !== 1'b0 || ped_ack !== 1'b0) begin
                errors++;
                $display("FAIL normal_cycle[%0d]: state=%0d ns=%b ew=%b walk=%b ack=%b required state=%0d ns=%b ew=%b walk=0 ack=0",
                         k, state, ns_light, ew_light, walk, ped_ack,
                         exp_seq[k], exp_ns(exp_seq[k]), exp_ew(exp_seq[k]));
            end
        end
    endtask

    task automatic test_ped_pulse();
        do_reset();
        tick = 1'b1;
        step();
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        wait_state(3'd3, 20, "pulse_reach_allred_a");
        step();
        checks++;
        if (state !== 3'd4 || ped_ack !== 1'b1 || dut.r_ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL pulse_walk_entry: state=%0d ack=%b pend=%b required 4/1/0",
                     state, ped_ack, dut.r_ped_pending);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (state !== 3'd4 || walk !== 1'b1 || ns_light !== 3'b100 || ew_light !== 3'b100 ||
                ped_ack !== (k == 0)) begin
                errors++;
                $display("FAIL pulse_walk[%0d]: state=%0d walk=%b ns=%b ew=%b ack=%b required 4/1/100/100/%0d",
                         k, state, walk, ns_light, ew_light, ped_ack, (k == 0));
            end
            step();
        end
        checks++;
        if (state !== 3'd5 || walk !== 1'b0 || ew_light !== 3'b001 || dut.r_ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL pulse_after_walk: state=%0d walk=%b ew=%b pend=%b required 5/0/001/0",
                     state, walk, ew_light, dut.r_ped_pending);
        end
    endtask

    task automatic test_ped_hold();
        int acks = 0;
        do_reset();
        tick = 1'b1;
        step();
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        wait_state(3'd4, 20, "hold_reach_walk_a");
        ped_req = 1'b1;
        for (int k = 0; k < 4; k++) step();
        ped_req = 1'b0;
        checks++;
        if (state !== 3'd5 || dut.r_ped_pending !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_relatch: state=%0d pend=%b required 5/0", state, dut.r_ped_pending);
        end
        for (int k = 0; k < 11; k++) begin
            if (ped_ack) acks++;
            step();
        end
        checks++;
        if (state !== 3'd1 || acks != 0) begin
            errors++;
            $display("FAIL hold_allred_b_exit: state=%0d acks=%0d required 1/0", state, acks);
        end
    endtask

    task automatic test_tick_every_3rd();
        logic [2:0] p_state, p_ns, p_ew;
        int green_cyc = 0;
        do_reset();
        for (int n = 0; n < 33; n++) begin
            p_state = state; p_ns = ns_light; p_ew = ew_light;
            tick = (n % 3 == 0);
            step();
            if (state === 3'd1) green_cyc++;
            if (!tick) begin
                checks++;
                if (state !== p_state || ns_light !== p_ns || ew_light !== p_ew) begin
                    errors++;
                    $display("FAIL tick3_stable[%0d]: state=%0d ns=%b ew=%b required %0d/%b/%b",
                             n, state, ns_light, ew_light, p_state, p_ns, p_ew);
                end
            end
        end
        tick = 1'b0;
        checks++;
        if (green_cyc != 24) begin
            errors++;
            $display("FAIL tick3_green_len: cycles=%0d required=24", green_cyc);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick = 1'b1;
        wait_state(3'd5, 20, "areset_reach_ew_green");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        wait_state(3'd6, 20, "areset_reach_ew_yellow");
        checks++;
        if (dut.r_ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL areset_pending_set: pend=%b required 1", dut.r_ped_pending);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || ns_light !== 3'b100 || ew_light !== 3'b100 ||
            dut.r_ped_pending !== 1'b0 || walk !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: state=%0d ns=%b ew=%b pend=%b walk=%b required 0/100/100/0/0",
                     state, ns_light, ew_light, dut.r_ped_pending, walk);
        end
        step();
        reset = 1'b0;
        tick  = 1'b0;
    endtask

    task automatic test_ped_on_decide();
        do_reset();
        tick = 1'b1;
        wait_state(3'd3, 20, "decide_reach_allred_a");
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        checks++;
        if (state !== 3'd5 || ped_ack !== 1'b0 || dut.r_ped_pending !== 1'b1) begin
            errors++;
            $display("FAIL decide_not_seen: state=%0d ack=%b pend=%b required 5/0/1",
                     state, ped_ack, dut.r_ped_pending);
        end
        wait_state(3'd0, 20, "decide_reach_allred_b");
        step();
        checks++;
        if (state !== 3'd7 || ped_ack !== 1'b1 || walk !== 1'b1 ||
            ns_light !== 3'b100 || ew_light !== 3'b100) begin
            errors++;
            $display("FAIL decide_walk_b: state=%0d ack=%b walk=%b ns=%b ew=%b required 7/1/1/100/100",
                     state, ped_ack, walk, ns_light, ew_light);
        end
        for (int k = 0; k < 4; k++) step();
        checks++;
        if (state !== 3'd1 || ns_light !== 3'b001 || walk !== 1'b0) begin
            errors++;
            $display("FAIL decide_after_walk_b: state=%0d ns=%b walk=%b required 1/001/0",
                     state, ns_light, walk);
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; ped_req = 1'b0;
        test_reset();
        test_normal_cycle();
        test_ped_pulse();
        test_ped_hold();
        test_tick_every_3rd();
        test_async_reset();
        test_ped_on_decide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
